pitch_sequencer: RTL and testbench

Timed phase sequencer that drives the two-motor throw/hit mechanism. A one-cycle `start` request runs one full pitch cycle: throw motor burst, aim delay, hit-arm swing, arm return and cooldown. It emits the `hitmode` and `throw` command signals consumed by the motor driver, which owns the PWM generation and direction pins. The block sits between the game/button control logic and the motor driver. All timing derives from the 100 MHz `clk`.

---
 rtl/pitch_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_pitch_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pitch_sequencer.sv
// Timed phase sequencer for the throw/hit mechanism: THROW, AIM, SWING, RETURN, COOL.
// Define PITCH_HOME_SENSE_EN to end RETURN on the arm home switch, with a timeout fault flag.
module pitch_sequencer #(
  parameter int unsigned THROW_CYC  = 50_000_000,
  parameter int unsigned AIM_CYC    = 20_000_000,
  parameter int unsigned SWING_CYC  = 15_000_000,
  parameter int unsigned RETURN_CYC = 30_000_000,
  parameter int unsigned COOL_CYC   = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
`ifdef PITCH_HOME_SENSE_EN
  input  logic       home,
`endif
  output logic [1:0] hitmode,
  output logic       throw,
  output logic       busy,
  output logic       done,
  output logic [2:0] state,
  output logic [7:0] pitch_cnt
`ifdef PITCH_HOME_SENSE_EN
  ,
  output logic       home_fault
`endif
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StThrow  = 3'd1,
    StAim    = 3'd2,
    StSwing  = 3'd3,
    StReturn = 3'd4,
    StCool   = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        abort_q;
  logic        return_timeout;
  logic        home_hit;
  logic        done_d;
  logic [7:0]  pitch_cnt_q, pitch_cnt_d;
  logic [1:0]  hitmode_q, hitmode_d;
  logic        throw_q, throw_d;
  logic        busy_q, busy_d;
  logic        done_q;

`ifdef PITCH_HOME_SENSE_EN
  logic home_meta_q, home_sync_q;
  logic home_fault_q, home_fault_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      home_meta_q <= 1'b0;
      home_sync_q <= 1'b0;
    end else begin
      home_meta_q <= home;
      home_sync_q <= home_meta_q;
    end
  end

  assign home_hit = home_sync_q;
`else
  assign home_hit = 1'b0;
`endif

  // State register and phase counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      abort_q <= abort;
    end
  end

  // Next-state logic; abort is registered so it acts one edge after being sampled.
  always_comb begin
    state_d        = state_q;
    return_timeout = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) state_d = StThrow;
      end
      StThrow: begin
        if (abort_q) begin
          state_d = StIdle;
        end else if (cnt_q == THROW_CYC - 1) begin
          state_d = StAim;
        end
      end
      StAim: begin
        if (abort_q) begin
          state_d = StIdle;
        end else if (cnt_q == AIM_CYC - 1) begin
          state_d = StSwing;
        end
      end
      StSwing: begin
        // Abort during the swing still brings the arm home.
        if (abort_q || (cnt_q == SWING_CYC - 1)) state_d = StReturn;
      end
      StReturn: begin
        return_timeout = (cnt_q == RETURN_CYC - 1);
        if (home_hit || return_timeout) state_d = StCool;
      end
      StCool: begin
        if (cnt_q == COOL_CYC - 1) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q + 32'd1;
    if ((state_d != state_q) || (state_d == StIdle)) cnt_d = '0;
  end

  // Output next values decode the next state so the registered outputs track state_q exactly.
  always_comb begin
    hitmode_d   = 2'd0;
    throw_d     = 1'b0;
    busy_d      = (state_d != StIdle);
    done_d      = (state_q == StCool) && (state_d == StIdle);
    pitch_cnt_d = pitch_cnt_q;
    if (done_d) pitch_cnt_d = pitch_cnt_q + 8'd1;
    case (state_d)
      StThrow:  throw_d   = 1'b1;
      StSwing:  hitmode_d = 2'd1;
      StReturn: hitmode_d = 2'd3;
      default:  hitmode_d = 2'd0;
    endcase
  end

`ifdef PITCH_HOME_SENSE_EN
  always_comb begin
    home_fault_d = home_fault_q;
    if ((state_q == StIdle) && start) begin
      home_fault_d = 1'b0;
    end else if ((state_q == StReturn) && return_timeout && !home_hit) begin
      home_fault_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      home_fault_q <= 1'b0;
    end else begin
      home_fault_q <= home_fault_d;
    end
  end

  assign home_fault = home_fault_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hitmode_q   <= 2'd0;
      throw_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pitch_cnt_q <= 8'd0;
    end else begin
      hitmode_q   <= hitmode_d;
      throw_q     <= throw_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pitch_cnt_q <= pitch_cnt_d;
    end
  end

  assign hitmode   = hitmode_q;
  assign throw     = throw_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign state     = state_q;
  assign pitch_cnt = pitch_cnt_q;

endmodule

// File: tb/tb_pitch_sequencer.sv
// Directed self-checking bench for pitch_sequencer with short phase lengths (4/3/5/6/2).
module tb_pitch_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic       home;
  logic [1:0] hitmode;
  logic       throw;
  logic       busy;
  logic       done;
  logic [2:0] state;
  logic [7:0] pitch_cnt;
  logic       home_fault;

  int n_checks = 0;
  int n_errors = 0;

  // Expected state after edges 0..20 of a normal pitch started at edge 0.
  int exp_norm [21] = '{1, 1, 1, 1, 2, 2, 2, 3, 3, 3, 3, 3, 4, 4, 4, 4, 4, 4, 5, 5, 0};
  // Expected state after edges 9..17 when abort is sampled at edge 8.
  int exp_abort [9] = '{4, 4, 4, 4, 4, 4, 5, 5, 0};

  pitch_sequencer #(
    .THROW_CYC (4),
    .AIM_CYC   (3),
    .SWING_CYC (5),
    .RETURN_CYC(6),
    .COOL_CYC  (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
`ifdef PITCH_HOME_SENSE_EN
    .home     (home),
`endif
    .hitmode  (hitmode),
    .throw    (throw),
    .busy     (busy),
    .done     (done),
    .state    (state),
    .pitch_cnt(pitch_cnt)
`ifdef PITCH_HOME_SENSE_EN
    ,
    .home_fault(home_fault)
`endif
  );

`ifndef PITCH_HOME_SENSE_EN
  assign home_fault = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int hm_of(input int s);
    if (s == 3) return 1;
    if (s == 4) return 3;
    return 0;
  endfunction

  task automatic check_reset(input string tag);
    check_eq({tag, "_state"}, state, 0);
    check_eq({tag, "_hitmode"}, hitmode, 0);
    check_eq({tag, "_throw"}, throw, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_pcnt"}, pitch_cnt, 0);
    check_eq({tag, "_fault"}, home_fault, 0);
  endtask

  initial begin
    int ndone;
    int t;
    rst   = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    home  = 1'b0;
    tick();
    tick();
    check_reset("rst");
    rst = 1'b1;
    tick();

    // 1: normal pitch
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k <= 20; k++) begin
      if (k > 0) tick();
      check_eq("t1_state", state, exp_norm[k]);
      check_eq("t1_throw", throw, exp_norm[k] == 1);
      check_eq("t1_hitmode", hitmode, hm_of(exp_norm[k]));
      check_eq("t1_busy", busy, exp_norm[k] != 0);
      check_eq("t1_done", done, k == 20);
    end
    check_eq("t1_pcnt", pitch_cnt, 1);
    tick();
    check_eq("t1_done_low", done, 0);

    // 2: start pulses during a pitch are ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0;
    for (int k = 1; k <= 21; k++) begin
      start = (k == 2) || (k == 10) || (k == 19);
      tick();
      start = 1'b0;
      if (k <= 20) check_eq("t2_state", state, exp_norm[k]);
      if (done) ndone++;
    end
    check_eq("t2_ndone", ndone, 1);
    check_eq("t2_idle", state, 0);
    check_eq("t2_pcnt", pitch_cnt, 2);

    // 3: abort sampled at edge 5 in AIM
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("t3_aim", state, 2);
    tick();
    check_eq("t3_state", state, 0);
    check_eq("t3_hitmode", hitmode, 0);
    check_eq("t3_throw", throw, 0);
    check_eq("t3_busy", busy, 0);
    check_eq("t3_done", done, 0);
    ndone = 0;
    repeat (5) begin
      tick();
      if (done) ndone++;
    end
    check_eq("t3_nodone", ndone, 0);
    check_eq("t3_pcnt", pitch_cnt, 2);

    // 4: abort sampled at edge 8 in SWING
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("t4_swing", hitmode, 1);
    for (int k = 9; k <= 17; k++) begin
      tick();
      check_eq("t4_state", state, exp_abort[k-9]);
      check_eq("t4_hitmode", hitmode, hm_of(exp_abort[k-9]));
      check_eq("t4_done", done, k == 17);
    end
    check_eq("t4_pcnt", pitch_cnt, 3);

    // 5: 256 back-to-back pitches from reset wrap the counter
    rst = 1'b0;
    #1;
    check_reset("t5_rst");
    tick();
    rst = 1'b1;
    tick();
    start = 1'b1;
    ndone = 0;
    t = 0;
    while ((t < 6000) && (ndone < 256)) begin
      tick();
      if (t == 21) check_eq("t5_b2b", state, 1);
      if (done) begin
        ndone++;
        if (ndone == 1) check_eq("t5_first_done", t, 20);
        if (ndone == 255) check_eq("t5_pcnt255", pitch_cnt, 255);
        if (ndone == 256) begin
          check_eq("t5_pcnt_wrap", pitch_cnt, 0);
          check_eq("t5_last_done", t, 5375);
          start = 1'b0;
        end
      end
      t++;
    end
    start = 1'b0;
    check_eq("t5_ndone", ndone, 256);
    tick();

    // 5b: asynchronous reset mid-sequence
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    @(posedge clk);
    #2;
    check_eq("t5_pre_rst", hitmode, 1);
    rst = 1'b0;
    #1;
    check_reset("t5_async");
    tick();
    rst = 1'b1;
    tick();

`ifdef PITCH_HOME_SENSE_EN
    // 6a: home rises two cycles into RETURN
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (13) tick();
    home = 1'b1;
    tick();
    check_eq("t6a_ret14", state, 4);
    tick();
    check_eq("t6a_ret15", state, 4);
    tick();
    check_eq("t6a_cool", state, 5);
    check_eq("t6a_fault", home_fault, 0);
    tick();
    tick();
    check_eq("t6a_idle", state, 0);
    check_eq("t6a_done", done, 1);
    home = 1'b0;
    repeat (3) tick();

    // 6b: home never arrives, RETURN times out
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (17) tick();
    check_eq("t6b_ret17", state, 4);
    check_eq("t6b_fault_pre", home_fault, 0);
    tick();
    check_eq("t6b_cool", state, 5);
    check_eq("t6b_fault", home_fault, 1);
    tick();
    tick();
    check_eq("t6b_done", done, 1);
    repeat (3) tick();
    check_eq("t6b_sticky", home_fault, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("t6b_clear", home_fault, 0);
    check_eq("t6b_restart", state, 1);
    repeat (25) tick();
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
